// File: rtl/onchip_mem_xfer_pkg.sv
// Shared definitions for the on-chip memory transfer master:
// command op encoding and the transfer FSM state type.
package onchip_mem_xfer_pkg;

  localparam logic OP_FILL = 1'b0;
  localparam logic OP_COPY = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    RWAIT = 3'd2,
    WR    = 3'd3,
    DONE  = 3'd4
  } xfer_state_t;

endpackage

// File: rtl/onchip_mem_xfer_master.sv
// Avalon-MM master for a single-port on-chip RAM. Runs one command at a time:
// FILL writes a pattern to LEN words at DST, COPY moves LEN words SRC->DST in
// strictly ascending order (read, wait RD_LAT, write per word).
// Optional feature macro: XFER_CHECKSUM_EN adds the csum output, a running
// sum of every word written by the current command.
//
// Handshakes:
//   command: accepted on a clock edge where cmd_valid & cmd_ready; cmd_ready is
//            high only in IDLE, all fields are latched at that edge.
//   bus:     a cycle with chipselect high completes on the edge where
//            waitrequest is low; until then every bus output is held.
module onchip_mem_xfer_master
  import onchip_mem_xfer_pkg::*;
#(
  parameter int AW     = 15,
  parameter int DW     = 32,
  parameter int LW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_op,
  input  logic [AW-1:0]   cmd_src,
  input  logic [AW-1:0]   cmd_dst,
  input  logic [LW-1:0]   cmd_len,
  input  logic [DW-1:0]   cmd_pattern,
  output logic            busy,
  output logic            done,
  output logic [AW-1:0]   avm_address,
  output logic [DW/8-1:0] avm_byteenable,
  output logic            avm_chipselect,
  output logic            avm_write,
  output logic [DW-1:0]   avm_writedata,
  output logic            avm_clken,
  input  logic            avm_waitrequest,
  input  logic [DW-1:0]   avm_readdata,
`ifdef XFER_CHECKSUM_EN
  output logic [DW-1:0]   csum,
`endif
  output logic [2:0]      dbg_state
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  xfer_state_t   state;
  logic          op_q;
  logic [AW-1:0] src_ptr;
  logic [AW-1:0] dst_ptr;
  logic [LW-1:0] len_q;
  logic [LW-1:0] cnt_q;
  logic [CW-1:0] lat_cnt;

  // Byteenable is all-ones whenever a bus cycle is active; the RAM clock is always enabled.
  assign avm_byteenable = {(DW/8){avm_chipselect}};
  assign avm_clken      = 1'b1;
  assign dbg_state      = state;

  // Transfer FSM with registered bus and status outputs. done is a one-cycle
  // pulse; a zero-length command spends two cycles in DONE so its pulse lands
  // two cycles after acceptance without touching the bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      op_q           <= OP_FILL;
      src_ptr        <= '0;
      dst_ptr        <= '0;
      len_q          <= '0;
      cnt_q          <= '0;
      lat_cnt        <= '0;
      cmd_ready      <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      avm_chipselect <= 1'b0;
      avm_write      <= 1'b0;
      avm_address    <= '0;
      avm_writedata  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q      <= cmd_op;
            src_ptr   <= cmd_src;
            dst_ptr   <= cmd_dst;
            len_q     <= cmd_len;
            cnt_q     <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_len == '0) begin
              state <= DONE;
            end else if (cmd_op == OP_COPY) begin
              state          <= RD;
              avm_chipselect <= 1'b1;
              avm_write      <= 1'b0;
              avm_address    <= cmd_src;
            end else begin
              state          <= WR;
              avm_chipselect <= 1'b1;
              avm_write      <= 1'b1;
              avm_address    <= cmd_dst;
              avm_writedata  <= cmd_pattern;
            end
          end
        end
        RD: begin
          if (!avm_waitrequest) begin
            state          <= RWAIT;
            avm_chipselect <= 1'b0;
            lat_cnt        <= CW'(RD_LAT - 1);
            src_ptr        <= src_ptr + AW'(1);
          end
        end
        RWAIT: begin
          if (lat_cnt == '0) begin
            state          <= WR;
            avm_chipselect <= 1'b1;
            avm_write      <= 1'b1;
            avm_address    <= dst_ptr;
            avm_writedata  <= avm_readdata;
          end else begin
            lat_cnt <= lat_cnt - CW'(1);
          end
        end
        WR: begin
          if (!avm_waitrequest) begin
            dst_ptr <= dst_ptr + AW'(1);
            cnt_q   <= cnt_q + LW'(1);
            if (cnt_q + LW'(1) == len_q) begin
              state          <= DONE;
              avm_chipselect <= 1'b0;
              avm_write      <= 1'b0;
              done           <= 1'b1;
            end else if (op_q == OP_COPY) begin
              state       <= RD;
              avm_write   <= 1'b0;
              avm_address <= src_ptr;
            end else begin
              // FILL streams one word per clock; writedata keeps the pattern.
              avm_address <= dst_ptr + AW'(1);
            end
          end
        end
        DONE: begin
          if (!done) begin
            done <= 1'b1;
          end else begin
            state     <= IDLE;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: begin
          state          <= IDLE;
          busy           <= 1'b0;
          cmd_ready      <= 1'b1;
          avm_chipselect <= 1'b0;
          avm_write      <= 1'b0;
        end
      endcase
    end
  end

`ifdef XFER_CHECKSUM_EN
  // Running sum of accepted write data, cleared when a command is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csum <= '0;
    end else if (state == IDLE && cmd_valid) begin
      csum <= '0;
    end else if (state == WR && !avm_waitrequest) begin
      csum <= csum + avm_writedata;
    end
  end
`endif

endmodule

// File: tb/tb_onchip_mem_xfer_master.sv
// Testbench for onchip_mem_xfer_master: behavioural RAM slave with controllable
// waitrequest, array reference model of memory contents, expected-write queue.
module tb_onchip_mem_xfer_master;
  import onchip_mem_xfer_pkg::*;

  localparam int AW    = 15;
  localparam int DW    = 32;
  localparam int LW    = 16;
  localparam int DEPTH = 1 << AW;

  logic            clk;
  logic            reset_n;
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_op;
  logic [AW-1:0]   cmd_src;
  logic [AW-1:0]   cmd_dst;
  logic [LW-1:0]   cmd_len;
  logic [DW-1:0]   cmd_pattern;
  logic            busy;
  logic            done;
  logic [AW-1:0]   avm_address;
  logic [DW/8-1:0] avm_byteenable;
  logic            avm_chipselect;
  logic            avm_write;
  logic [DW-1:0]   avm_writedata;
  logic            avm_clken;
  logic            avm_waitrequest;
  logic [DW-1:0]   avm_readdata;
  logic [DW-1:0]   csum;
  logic [2:0]      dbg_state;

  logic [DW-1:0]       ram     [DEPTH];
  logic [DW-1:0]       ref_mem [DEPTH];
  logic [AW+DW-1:0]    exp_q[$];

  int vectors;
  int miscompares;
  bit stall_rand;
  int stall_at;
  int stall_left;
  int stall_count;
  int wr_idx;
  int cs_seen;
  bit held_valid;
  logic [AW+DW+1:0] held_bus;

  onchip_mem_xfer_master #(.AW(AW), .DW(DW), .LW(LW), .RD_LAT(1)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_src        (cmd_src),
    .cmd_dst        (cmd_dst),
    .cmd_len        (cmd_len),
    .cmd_pattern    (cmd_pattern),
    .busy           (busy),
    .done           (done),
    .avm_address    (avm_address),
    .avm_byteenable (avm_byteenable),
    .avm_chipselect (avm_chipselect),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_clken      (avm_clken),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata   (avm_readdata),
`ifdef XFER_CHECKSUM_EN
    .csum           (csum),
`endif
    .dbg_state      (dbg_state)
  );

`ifndef XFER_CHECKSUM_EN
  assign csum = '0;
`endif

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM slave: one-cycle read latency from the accepted read
  always @(posedge clk) begin
    if (avm_chipselect && !avm_waitrequest) begin
      if (avm_write) ram[avm_address] <= avm_writedata;
      else           avm_readdata     <= ram[avm_address];
    end
  end

  // Bus monitor: chooses waitrequest, checks held outputs and accepted writes
  always @(negedge clk) begin
    if (!reset_n) begin
      avm_waitrequest = 1'b0;
      held_valid      = 1'b0;
    end else begin
      if (held_valid) begin
        vectors++;
        if ({avm_chipselect, avm_write, avm_address, avm_writedata} !== held_bus) begin
          miscompares++;
          $display("FAIL stall_hold: got %h expected %h", {avm_chipselect, avm_write, avm_address, avm_writedata}, held_bus);
        end
      end
      avm_waitrequest = 1'b0;
      if (avm_chipselect) begin
        cs_seen++;
        vectors++;
        if (avm_byteenable !== 4'hF) begin
          miscompares++;
          $display("FAIL byteenable: got %h expected f", avm_byteenable);
        end
        if (stall_left > 0 && avm_write && wr_idx == stall_at) begin
          avm_waitrequest = 1'b1;
          stall_left--;
        end else if (stall_rand && $urandom_range(0, 3) == 0) begin
          avm_waitrequest = 1'b1;
        end
      end
      if (avm_waitrequest) begin
        stall_count++;
        held_valid = 1'b1;
        held_bus   = {avm_chipselect, avm_write, avm_address, avm_writedata};
      end else begin
        held_valid = 1'b0;
      end
      if (avm_chipselect && avm_write && !avm_waitrequest) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_write: got addr %h data %h expected none", avm_address, avm_writedata);
        end else begin
          logic [AW+DW-1:0] e;
          e = exp_q.pop_front();
          if ({avm_address, avm_writedata} !== e) begin
            miscompares++;
            $display("FAIL write_seq: got addr %h data %h expected addr %h data %h",
                     avm_address, avm_writedata, e[AW+DW-1:DW], e[DW-1:0]);
          end
        end
        wr_idx++;
      end
    end
  end

  // Run one command and check latency, write stream, checksum and return to idle
  task automatic run_cmd(input logic op, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                         input logic [LW-1:0] len, input logic [DW-1:0] pat, input string tag);
    int n;
    int exp_n;
    int cs_before;
    logic [AW-1:0] a_s;
    logic [AW-1:0] a_d;
    logic [DW-1:0] w;
    logic [DW-1:0] exp_csum;
    exp_csum = '0;
    for (int i = 0; i < int'(len); i++) begin
      a_s = src + AW'(i);
      a_d = dst + AW'(i);
      w   = (op == OP_COPY) ? ref_mem[a_s] : pat;
      ref_mem[a_d] = w;
      exp_q.push_back({a_d, w});
      exp_csum += w;
    end
    @(posedge clk); #1;
    wr_idx      = 0;
    stall_count = 0;
    cs_before   = cs_seen;
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_src     = src;
    cmd_dst     = dst;
    cmd_len     = len;
    cmd_pattern = pat;
    @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_ready_before: got %b expected 1", tag, cmd_ready);
    end
    @(posedge clk); #1;
    cmd_valid   = 1'b0;
    cmd_op      = 1'($urandom);
    cmd_src     = AW'($urandom);
    cmd_dst     = AW'($urandom);
    cmd_len     = LW'($urandom);
    cmd_pattern = $urandom;
    n = 1;
    while (n < 2000) begin
      @(negedge clk);
      if (n == 1) begin
        vectors++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
          miscompares++;
          $display("FAIL %s_busy: got ready %b busy %b expected ready 0 busy 1", tag, cmd_ready, busy);
        end
      end
      if (done === 1'b1) break;
      @(posedge clk);
      n++;
    end
    if (len == 0)            exp_n = 2;
    else if (op == OP_COPY)  exp_n = 3 * int'(len) + 1 + stall_count;
    else                     exp_n = int'(len) + 1 + stall_count;
    vectors++;
    if (n != exp_n) begin
      miscompares++;
      $display("FAIL %s_latency: got %0d cycles expected %0d", tag, n, exp_n);
    end
`ifdef XFER_CHECKSUM_EN
    vectors++;
    if (csum !== exp_csum) begin
      miscompares++;
      $display("FAIL %s_csum: got %h expected %h", tag, csum, exp_csum);
    end
`endif
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_idle: got done %b busy %b ready %b expected 0 0 1", tag, done, busy, cmd_ready);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_missing_writes: got %0d left expected 0", tag, exp_q.size());
      exp_q.delete();
    end
    if (len == 0) begin
      vectors++;
      if (cs_seen != cs_before) begin
        miscompares++;
        $display("FAIL %s_no_bus: got %0d chipselect cycles expected 0", tag, cs_seen - cs_before);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || avm_chipselect !== 1'b0 ||
        avm_write !== 1'b0 || avm_address !== '0 || avm_writedata !== '0 || csum !== '0) begin
      miscompares++;
      $display("FAIL reset_values: got done %b busy %b ready %b cs %b wr %b addr %h data %h csum %h expected 0 0 1 0 0 0 0 0",
               done, busy, cmd_ready, avm_chipselect, avm_write, avm_address, avm_writedata, csum);
    end
    reset_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (avm_clken !== 1'b1 || cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL after_reset: got clken %b ready %b expected 1 1", avm_clken, cmd_ready);
    end
  endtask

  task automatic test_fill();
    run_cmd(OP_FILL, 15'h0000, 15'h0010, 16'd4, 32'hDEADBEEF, "fill");
  endtask

  task automatic test_copy();
    for (int i = 0; i < 3; i++) begin
      ram[15'h0100 + i]     = 32'(i + 1);
      ref_mem[15'h0100 + i] = 32'(i + 1);
    end
    run_cmd(OP_COPY, 15'h0100, 15'h0200, 16'd3, 32'h0, "copy");
  endtask

  task automatic test_fill_wrap();
    run_cmd(OP_FILL, 15'h0000, 15'h7FFE, 16'd4, 32'h0BADF00D, "fill_wrap");
    run_cmd(OP_COPY, 15'h7FFF, 15'h0300, 16'd3, 32'h0, "copy_wrap");
  endtask

  task automatic test_len_zero();
    run_cmd(OP_FILL, 15'h0000, 15'h0040, 16'd0, 32'h12345678, "fill_len0");
    run_cmd(OP_COPY, 15'h0100, 15'h0040, 16'd0, 32'h0, "copy_len0");
  endtask

  task automatic test_waitrequest();
    stall_at   = 1;
    stall_left = 3;
    run_cmd(OP_FILL, 15'h0000, 15'h0050, 16'd4, 32'hA5A5_0F0F, "fill_stall");
    vectors++;
    if (stall_count != 3) begin
      miscompares++;
      $display("FAIL fill_stall_count: got %0d expected 3", stall_count);
    end
    stall_left = 0;
  endtask

  task automatic test_overlap();
    for (int i = 0; i < 4; i++) begin
      ram[15'h0500 + i]     = 32'hC0DE_0000 + 32'(i);
      ref_mem[15'h0500 + i] = 32'hC0DE_0000 + 32'(i);
    end
    run_cmd(OP_COPY, 15'h0500, 15'h0501, 16'd4, 32'h0, "copy_overlap");
  endtask

  task automatic test_checksum_wrap();
    run_cmd(OP_FILL, 15'h0000, 15'h0600, 16'd2, 32'h8000_0000, "csum_wrap");
  endtask

  task automatic test_random();
    logic [AW-1:0] s;
    logic [AW-1:0] d;
    stall_rand = 1'b1;
    for (int k = 0; k < 12; k++) begin
      s = ($urandom_range(0, 1) == 1) ? AW'(DEPTH - $urandom_range(1, 4)) : AW'($urandom);
      d = ($urandom_range(0, 1) == 1) ? AW'(DEPTH - $urandom_range(1, 4)) : AW'($urandom);
      run_cmd(1'($urandom), s, d, LW'($urandom_range(0, 6)), $urandom, "random");
    end
    stall_rand = 1'b0;
  endtask

  task automatic test_reset_abort();
    int guard;
    bit hit;
    for (int i = 0; i < 4; i++) begin
      ram[15'h0700 + i]     = 32'h5500_0000 + 32'(i);
      ref_mem[15'h0700 + i] = 32'h5500_0000 + 32'(i);
    end
    ref_mem[15'h0710] = ref_mem[15'h0700];
    exp_q.push_back({15'h0710, ref_mem[15'h0700]});
    @(posedge clk); #1;
    wr_idx      = 0;
    cmd_valid   = 1'b1;
    cmd_op      = OP_COPY;
    cmd_src     = 15'h0700;
    cmd_dst     = 15'h0710;
    cmd_len     = 16'd4;
    cmd_pattern = '0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    hit   = 1'b0;
    guard = 0;
    while (!hit && guard < 200) begin
      @(negedge clk); #1;
      if (wr_idx == 1 && avm_chipselect === 1'b1 && avm_write === 1'b0) hit = 1'b1;
      guard++;
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL abort_reach_word2: got timeout expected read of word 2");
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if (avm_chipselect !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || avm_write !== 1'b0 ||
        avm_address !== '0 || done !== 1'b0 || csum !== '0) begin
      miscompares++;
      $display("FAIL abort_values: got cs %b busy %b ready %b wr %b addr %h done %b csum %h expected 0 0 1 0 0 0 0",
               avm_chipselect, busy, cmd_ready, avm_write, avm_address, done, csum);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL abort_first_write: got %0d left expected 0", exp_q.size());
      exp_q.delete();
    end
    run_cmd(OP_FILL, 15'h0000, 15'h0720, 16'd2, 32'h1111_2222, "after_abort");
  endtask

  task automatic check_image();
    int errs;
    errs = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ram[i] !== ref_mem[i]) errs++;
    end
    vectors++;
    if (errs != 0) begin
      miscompares++;
      $display("FAIL ram_image: got %0d differing words expected 0", errs);
    end
  endtask

  initial begin
    vectors         = 0;
    miscompares     = 0;
    stall_rand      = 1'b0;
    stall_at        = 0;
    stall_left      = 0;
    stall_count     = 0;
    wr_idx          = 0;
    cs_seen         = 0;
    held_valid      = 1'b0;
    held_bus        = '0;
    reset_n         = 1'b0;
    cmd_valid       = 1'b0;
    cmd_op          = OP_FILL;
    cmd_src         = '0;
    cmd_dst         = '0;
    cmd_len         = '0;
    cmd_pattern     = '0;
    avm_waitrequest = 1'b0;
    avm_readdata    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = $urandom;
      ref_mem[i] = ram[i];
    end
    test_reset();
    test_fill();
    test_copy();
    test_fill_wrap();
    test_len_zero();
    test_waitrequest();
    test_overlap();
    test_checksum_wrap();
    test_random();
    test_reset_abort();
    check_image();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
